// File: rtl/datapath_wb_pkg.sv
// ----------------------------------------------------------------------------
// datapath_wb_pkg: shared types and default constants for the writeback stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package datapath_wb_pkg;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_RUN  = 2'd1,
      WB_DONE = 2'd2
   } wb_state_t;

   localparam int WB_DATA_W      = 64;
   localparam int WB_ADDR_STRIDE = 8;
   localparam int WB_FIFO_DEPTH  = 4;

endpackage

`default_nettype wire

// File: rtl/datapath_writeback_fifo.sv
// ----------------------------------------------------------------------------
// wb_sync_fifo: registered-storage synchronous FIFO, no fall-through
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_sync_fifo
   import datapath_wb_pkg::*;
#(
   parameter int WIDTH = WB_DATA_W,
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else begin
         if (do_push) begin
            storage[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = storage[rd_ptr];
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);

endmodule

`default_nettype wire

// File: rtl/datapath_writeback.sv
// ----------------------------------------------------------------------------
// datapath_writeback: buffers datapath result words and writes them to memory
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module datapath_writeback
   import datapath_wb_pkg::*;
#(
   parameter int DATA_W      = WB_DATA_W,
   parameter int ADDR_W      = 16,
   parameter int ADDR_STRIDE = WB_ADDR_STRIDE,
   parameter int FIFO_DEPTH  = WB_FIFO_DEPTH,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              mem_wr_valid,
   input  logic              mem_wr_ready,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_state_t         state;
   wb_state_t         state_next;
   logic [CNT_W-1:0]  num_reg;
   logic [CNT_W-1:0]  recv_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  drop_cnt;
   logic [ADDR_W-1:0] addr_reg;
   logic              overflow_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic              has_room;
   logic              accept_word;
   logic              push;
   logic              pop;
   logic              drop_word;
   logic [CNT_W:0]    retired_next;

   wb_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head_data (mem_wr_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign mem_wr_valid = (state == WB_RUN) && !fifo_empty;
   assign pop          = mem_wr_valid && mem_wr_ready;
   assign has_room     = (fifo_count < FCNT_W'(FIFO_DEPTH)) || pop;

   // Words past num_words are ignored; words that find no room are counted as retired.
   assign accept_word  = (state == WB_RUN) && in_valid && (recv_cnt < num_reg);
   assign push         = accept_word && has_room;
   assign drop_word    = accept_word && fifo_full && !pop;

   assign retired_next = {1'b0, wr_cnt} + {1'b0, drop_cnt}
                       + (CNT_W+1)'(pop) + (CNT_W+1)'(drop_word);

   assign mem_wr_addr  = addr_reg;
   assign busy         = (state == WB_RUN);
   assign done         = (state == WB_DONE);
   assign overflow     = overflow_reg;

   always_comb begin
      state_next = state;
      case (state)
         WB_IDLE: begin
            if (start) begin
               state_next = (num_words == '0) ? WB_DONE : WB_RUN;
            end
         end
         WB_RUN: begin
            if (retired_next == {1'b0, num_reg}) begin
               state_next = WB_DONE;
            end
         end
         WB_DONE: state_next = WB_IDLE;
         default: state_next = WB_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= WB_IDLE;
         num_reg      <= '0;
         recv_cnt     <= '0;
         wr_cnt       <= '0;
         drop_cnt     <= '0;
         addr_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            WB_IDLE: begin
               if (start) begin
                  num_reg      <= num_words;
                  addr_reg     <= base_addr;
                  recv_cnt     <= '0;
                  wr_cnt       <= '0;
                  drop_cnt     <= '0;
                  overflow_reg <= 1'b0;
               end
            end
            WB_RUN: begin
               if (accept_word) begin
                  recv_cnt <= recv_cnt + CNT_W'(1);
               end
               if (pop) begin
                  wr_cnt   <= wr_cnt + CNT_W'(1);
                  addr_reg <= addr_reg + ADDR_W'(ADDR_STRIDE);
               end
               if (drop_word) begin
                  drop_cnt     <= drop_cnt + CNT_W'(1);
                  overflow_reg <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/datapath_writeback.md
Name: datapath_writeback

Overview:
Downstream stage of the negator datapath. It collects the 64-bit result words the datapath emits as single-cycle output_valid pulses; that interface has no backpressure. It buffers the words in a small FIFO and writes them to memory through a valid/ready write port at consecutive addresses. A start/done control pair frames each job of num_words results. Words that cannot be buffered are dropped and flagged.

Parameters:
DATA_W, 64, width of result word and memory write data
ADDR_W, 16, width of memory byte address
ADDR_STRIDE, 8, byte increment between consecutive writes
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 16, width of num_words and internal word counters

Ports:
clock  in  1  clock; all state updates on posedge
reset  in  1  reset, synchronous, active-high
start  in  1  job start pulse; sampled only in IDLE
base_addr  in  ADDR_W  first write address; latched on accepted start
num_words  in  CNT_W  results expected in the job; latched on accepted start
in_valid  in  1  result word valid; connects to datapath output_valid
in_data  in  DATA_W  result word; connects to datapath output_data
mem_wr_valid  out  1  write request valid
mem_wr_ready  in  1  memory accepts write
mem_wr_addr  out  ADDR_W  write byte address
mem_wr_data  out  DATA_W  write data
busy  out  1  high while state is RUN
done  out  1  one-cycle pulse at job completion
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset values: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, overflow=0. FIFO empty, all counters 0, state IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 latches base_addr into the address register, latches num_words, clears the received and written counters, clears overflow.
  - Next state is RUN, or DONE if num_words==0.
  - in_valid in IDLE is ignored: no push, no flag.
- RUN, push side:
  - Push when in_valid && recv_cnt<num_words && (!full || pop this cycle).
  - A push increments recv_cnt.
  - in_valid && recv_cnt<num_words && full && !pop: the word is dropped, overflow is set, recv_cnt still increments so the job can finish.
  - in_valid with recv_cnt==num_words: extra word is silently dropped, no flag.
- RUN, write side:
  - mem_wr_valid = !empty. mem_wr_data = FIFO head. mem_wr_addr = current address register.
  - Transfer (pop) occurs when mem_wr_valid && mem_wr_ready.
  - On transfer: pop, address += ADDR_STRIDE (wraps modulo 2^ADDR_W), wr_cnt++.
  - Once asserted, mem_wr_valid and its addr/data hold stable until the transfer.
- Latency: a word pushed on edge N is presented on mem_wr_valid in cycle N+1 when the FIFO was empty (registered storage, no fall-through).
- Simultaneous push and pop on a full FIFO is legal: count unchanged, no drop.
- Completion:
  - Condition: wr_cnt + dropped_cnt == num_words, evaluated after the cycle's updates. Dropped words count as retired.
  - Next state is DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. overflow holds until the next accepted start or reset.
- start outside IDLE is ignored.
- Reset mid-job: immediate return to reset values. FIFO contents are discarded and any pending write is abandoned.
- Counters are unsigned CNT_W. num_words up to 2^CNT_W-1 is supported.

Decomposition:
- Package datapath_wb_pkg holds:
  - state enum wb_state_t {WB_IDLE, WB_RUN, WB_DONE}
  - default constants WB_DATA_W=64, WB_ADDR_STRIDE=8, WB_FIFO_DEPTH=4
- One sub-module: wb_sync_fifo.
  - Parameterized by width and depth.
  - Ports: push, push_data, pop, head_data, full, empty, count.
  - Synchronous reset; simultaneous push/pop when full allowed.
- The FSM, counters and address generation live in datapath_writeback.

Test Plan:
1. start, base_addr=0x0100, num_words=2; in_valid pulses with 0xFFFFFFFE_FFFFFFFF and 0x00000001_80000000 three cycles apart; mem_wr_ready=1 -> writes (0x0100, first word), (0x0108, second word); done pulses one cycle after second transfer; overflow=0.
2. Backpressure: num_words=3, mem_wr_ready=0 for 10 cycles while 3 words arrive -> mem_wr_valid stays 1 with addr/data stable at word0; after ready rises, 3 writes at 0x0100/0x0108/0x0110 in order.
3. Overflow: FIFO_DEPTH=4, ready=0, 5 words with num_words=5 -> 5th dropped, overflow=1; after ready, exactly 4 writes, done pulses, overflow stays 1 until next start.
4. Full FIFO with push and pop in the same cycle: fill 4 entries, ready=1 on the cycle a 5th word arrives -> no drop, overflow=0, 5 writes in order.
5. num_words=0 -> done pulses the cycle after start, no mem_wr_valid. Extra words beyond num_words are ignored. start while busy is ignored.
6. Reset asserted mid-job with 2 words buffered -> next cycle mem_wr_valid=0, busy=0, done=0; a new start with base_addr=0x0200 writes from 0x0200; address wrap 0xFFF8 -> 0x0000 verified.
